// File: rtl/traffic_ctrl_param.sv
// Highway/country intersection controller with yellow phases, a highway car quota,
// snow-extended yellow, optional country demand sensing and a defined sys_en-drop policy.
module traffic_ctrl_param #(
  parameter int HWY_CARS      = 3,
  parameter int YEL_CYCLES    = 1,
  parameter int CG_CYCLES     = 2,
  parameter int SNOW_EXTRA    = 2,
  parameter int COUNTRY_SENSE = 0,
  parameter int CW            = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sys_en,
  input  logic          vehicle,
  input  logic          snow,
  input  logic          country_req,
  output logic          gh,
  output logic          yh,
  output logic          rh,
  output logic          gc,
  output logic          yc,
  output logic          rc,
  output logic [1:0]    state,
  output logic [CW-1:0] car_cnt
);

  typedef enum logic [1:0] {
    HG = 2'b00,
    HY = 2'b01,
    CG = 2'b10,
    CY = 2'b11
  } phase_t;

  localparam logic [CW-1:0] QUOTA         = CW'(HWY_CARS);
  localparam logic [CW-1:0] QUOTA_M1      = CW'(HWY_CARS - 1);
  localparam logic [CW-1:0] YEL_LOAD      = CW'(YEL_CYCLES - 1);
  localparam logic [CW-1:0] YEL_SNOW_LOAD = CW'(YEL_CYCLES + SNOW_EXTRA - 1);
  localparam logic [CW-1:0] CG_LOAD       = CW'(CG_CYCLES - 1);
  localparam logic          SENSE         = (COUNTRY_SENSE != 0);

  phase_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] timer_q, timer_d;

  logic          quota_hit;
  logic          can_count;
  logic          country_ok;
  logic          timer_done;
  logic [CW-1:0] yel_load;

  assign quota_hit  = (cnt_q == QUOTA) || (vehicle && (cnt_q == QUOTA_M1));
  assign can_count  = vehicle && (cnt_q != QUOTA);
  assign country_ok = !SENSE || country_req;
  assign timer_done = (timer_q == '0);
  // The snow sample at yellow entry is held in the loaded timer value, so later
  // snow changes cannot stretch or shorten a yellow already in progress.
  assign yel_load   = snow ? YEL_SNOW_LOAD : YEL_LOAD;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the pre-edge
    // values computed by the combinational blocks, independent of statement order.
    if (reset) begin
      state_q <= HG;
      cnt_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    unique case (state_q)
      HG: begin
        if (sys_en) begin
          if (can_count) cnt_d = cnt_q + 1'b1;
          if (quota_hit && country_ok) begin
            state_d = HY;
            timer_d = yel_load;
          end
        end
      end
      HY: begin
        if (!sys_en) begin
          state_d = HG;
          timer_d = '0;
        end else if (timer_done) begin
          state_d = CG;
          timer_d = CG_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      CG: begin
        if (!sys_en || timer_done) begin
          state_d = CY;
          timer_d = yel_load;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      CY: begin
        // Country yellow always runs to completion so the road is cleared.
        if (timer_done) begin
          state_d = HG;
          cnt_d   = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = HG;
        cnt_d   = '0;
        timer_d = '0;
      end
    endcase
  end

  // Lamp decode straight from the state register
  always_comb begin
    gh = 1'b0;
    yh = 1'b0;
    rh = 1'b0;
    gc = 1'b0;
    yc = 1'b0;
    rc = 1'b0;
    unique case (state_q)
      HG: begin gh = 1'b1; rc = 1'b1; end
      HY: begin yh = 1'b1; rc = 1'b1; end
      CG: begin rh = 1'b1; gc = 1'b1; end
      CY: begin rh = 1'b1; yc = 1'b1; end
      default: begin gh = 1'b1; rc = 1'b1; end
    endcase
  end

  assign state   = state_q;
  assign car_cnt = cnt_q;

endmodule
